rr_select_arbiter16: RTL and testbench

Round-robin arbiter and sequencer for the shared 16-input, MSB-first select mux. Up to 16 requesters contend for the mux. The block grants one requester at a time, drives the 4-bit mux select for that requester, and holds it until the owner releases it or a hold-limit timeout forces preemption. Slot numbering matches the mux: slot `s` (select value) corresponds to data bit `a[15-s]` and to request bit `req[15-s]`.

---
 rtl/rr_select_arbiter16_if.sv | 13 +
 rtl/rr_select_arbiter16.sv | 103 ++++++++++
 tb/tb_rr_select_arbiter16.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/rr_select_arbiter16_if.sv
// Bundle of request/release inputs and grant outputs for the 16-slot select-mux arbiter.
// Bit 15-s of req/done/gnt belongs to mux slot s.
interface rr_select_arbiter16_if;
  logic [15:0] req;
  logic [15:0] done;
  logic [3:0]  sel;
  logic [15:0] gnt;
  logic        gnt_valid;
  logic        preempt;

  modport master (output req, done, input sel, gnt, gnt_valid, preempt);
  modport slave  (input req, done, output sel, gnt, gnt_valid, preempt);
endinterface

// File: rtl/rr_select_arbiter16.sv
// Round-robin owner selection for the shared MSB-first 16:1 mux, with optional
// hold-limit preemption. All outputs come straight from flops.
module rr_select_arbiter16 #(
  parameter int MAX_HOLD = 16,
  parameter int HOLD_W   = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  rr_select_arbiter16_if.slave  bus
);
  typedef enum logic {IDLE, BUSY} state_t;

  state_t              state_q, state_d;
  logic [3:0]          last_q, last_d;
  logic [3:0]          sel_q, sel_d;
  logic [15:0]         gnt_q, gnt_d;
  logic                gnt_valid_q, gnt_valid_d;
  logic                preempt_q, preempt_d;
  logic [HOLD_W-1:0]   cnt_q, cnt_d;

  logic       hit;
  logic [3:0] hit_slot;
  logic [3:0] slot;
  logic       own_req, own_done, timeout, release_now;

  // First requesting slot strictly after the last owner, wrapping at 16.
  always_comb begin
    hit      = 1'b0;
    hit_slot = '0;
    slot     = '0;
    for (int i = 1; i <= 16; i++) begin
      slot = last_q + 4'(i);
      if (!hit && bus.req[4'd15 - slot]) begin
        hit      = 1'b1;
        hit_slot = slot;
      end
    end
  end

  assign own_req     = bus.req[4'd15 - sel_q];
  assign own_done    = bus.done[4'd15 - sel_q];
  assign timeout     = (MAX_HOLD != 0) && (cnt_q == HOLD_W'(MAX_HOLD - 1));
  assign release_now = own_done || !own_req || timeout;

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    sel_d       = sel_q;
    gnt_d       = gnt_q;
    gnt_valid_d = gnt_valid_q;
    preempt_d   = 1'b0;
    cnt_d       = cnt_q;
    case (state_q)
      IDLE: begin
        if (hit) begin
          state_d     = BUSY;
          sel_d       = hit_slot;
          gnt_d       = 16'h8000 >> hit_slot;
          gnt_valid_d = 1'b1;
          last_d      = hit_slot;
          cnt_d       = '0;
        end
      end
      BUSY: begin
        if (release_now) begin
          state_d     = IDLE;
          gnt_d       = '0;
          gnt_valid_d = 1'b0;
          // Timeout only counts as preemption when the owner had not let go anyway.
          preempt_d   = timeout && own_req && !own_done;
        end else if (cnt_q != {HOLD_W{1'b1}}) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      last_q      <= 4'd15;
      sel_q       <= '0;
      gnt_q       <= '0;
      gnt_valid_q <= 1'b0;
      preempt_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      sel_q       <= sel_d;
      gnt_q       <= gnt_d;
      gnt_valid_q <= gnt_valid_d;
      preempt_q   <= preempt_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.sel       = sel_q;
  assign bus.gnt       = gnt_q;
  assign bus.gnt_valid = gnt_valid_q;
  assign bus.preempt   = preempt_q;
endmodule

// File: tb/tb_rr_select_arbiter16.sv
// Directed bench for rr_select_arbiter16: a vector table plus hand-written
// sequences for rotation, timeout, coincident release and async reset.
module tb_rr_select_arbiter16;
  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;

  rr_select_arbiter16_if ifc();
  rr_select_arbiter16 #(.MAX_HOLD(16), .HOLD_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] req;
    logic [15:0] done;
    logic [3:0]  sel;
    logic [15:0] gnt;
    logic        vld;
    logic        pre;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  // sel is only meaningful while a grant is held.
  task automatic chk_out(input string tag, input logic [3:0] s, input logic [15:0] g,
                         input logic v, input logic p);
    chk({tag, ".gnt_valid"}, 32'(ifc.gnt_valid), 32'(v));
    chk({tag, ".gnt"},       32'(ifc.gnt),       32'(g));
    chk({tag, ".preempt"},   32'(ifc.preempt),   32'(p));
    if (v) chk({tag, ".sel"}, 32'(ifc.sel), 32'(s));
  endtask

  task automatic step(input logic [15:0] r, input logic [15:0] d);
    ifc.req  = r;
    ifc.done = d;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    ifc.req  = '0;
    ifc.done = '0;
    reset    = 1'b1;
    @(posedge clk);
    #1;
    reset    = 1'b0;
  endtask

  initial begin
    reset    = 1'b1;
    ifc.req  = '0;
    ifc.done = '0;

    //        req       done      sel    gnt       vld   pre
    tbl[0]  = '{16'h8000, 16'h0000, 4'd0,  16'h8000, 1'b1, 1'b0};
    tbl[1]  = '{16'h8000, 16'h8000, 4'd0,  16'h0000, 1'b0, 1'b0};
    tbl[2]  = '{16'h0000, 16'h8000, 4'd0,  16'h0000, 1'b0, 1'b0};
    tbl[3]  = '{16'h0001, 16'h0000, 4'd15, 16'h0001, 1'b1, 1'b0};
    tbl[4]  = '{16'h0001, 16'h8000, 4'd15, 16'h0001, 1'b1, 1'b0};
    tbl[5]  = '{16'h0000, 16'h0000, 4'd0,  16'h0000, 1'b0, 1'b0};
    tbl[6]  = '{16'h1000, 16'h0000, 4'd3,  16'h1000, 1'b1, 1'b0};
    tbl[7]  = '{16'h1001, 16'h0001, 4'd3,  16'h1000, 1'b1, 1'b0};
    tbl[8]  = '{16'h0001, 16'h0000, 4'd0,  16'h0000, 1'b0, 1'b0};
    tbl[9]  = '{16'h0001, 16'h0000, 4'd15, 16'h0001, 1'b1, 1'b0};
    tbl[10] = '{16'h0001, 16'h0001, 4'd0,  16'h0000, 1'b0, 1'b0};
    tbl[11] = '{16'h0001, 16'h0000, 4'd15, 16'h0001, 1'b1, 1'b0};
    tbl[12] = '{16'h0001, 16'h0001, 4'd0,  16'h0000, 1'b0, 1'b0};

    #2;
    chk_out("reset", 4'd0, 16'h0000, 1'b0, 1'b0);
    chk("reset.sel", 32'(ifc.sel), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    for (int i = 0; i < 13; i++) begin
      step(tbl[i].req, tbl[i].done);
      chk_out($sformatf("tbl%0d", i), tbl[i].sel, tbl[i].gnt, tbl[i].vld, tbl[i].pre);
    end

    // Full rotation: every slot requests, owner releases with done each grant.
    do_reset();
    for (int k = 0; k < 17; k++) begin
      logic [3:0]  s;
      logic [15:0] g;
      s = 4'(k);
      g = 16'h8000 >> s;
      step(16'hFFFF, 16'h0000);
      chk_out($sformatf("rot%0d.grant", k), s, g, 1'b1, 1'b0);
      step(16'hFFFF, g);
      chk_out($sformatf("rot%0d.bubble", k), 4'd0, 16'h0000, 1'b0, 1'b0);
    end

    // Hold slot 0 past the limit: 16 visible cycles, preempt bubble, then slot 15.
    do_reset();
    for (int k = 0; k < 16; k++) begin
      step(16'h8001, 16'h0000);
      chk_out($sformatf("to.hold%0d", k), 4'd0, 16'h8000, 1'b1, 1'b0);
    end
    step(16'h8001, 16'h0000);
    chk_out("to.preempt", 4'd0, 16'h0000, 1'b0, 1'b1);
    step(16'h8001, 16'h0000);
    chk_out("to.next", 4'd15, 16'h0001, 1'b1, 1'b0);

    // done coincident with timeout is a normal release.
    do_reset();
    for (int k = 0; k < 16; k++) step(16'h8000, 16'h0000);
    chk_out("tod.last", 4'd0, 16'h8000, 1'b1, 1'b0);
    step(16'h8000, 16'h8000);
    chk_out("tod.release", 4'd0, 16'h0000, 1'b0, 1'b0);

    // req drop coincident with timeout is also a normal release.
    do_reset();
    for (int k = 0; k < 16; k++) step(16'h0100, 16'h0000);
    chk_out("tor.last", 4'd7, 16'h0100, 1'b1, 1'b0);
    step(16'h0000, 16'h0000);
    chk_out("tor.release", 4'd0, 16'h0000, 1'b0, 1'b0);

    // Async reset mid-grant, then restart from slot 0.
    do_reset();
    step(16'h0010, 16'h0000);
    step(16'h0010, 16'h0000);
    chk_out("ar.held", 4'd11, 16'h0010, 1'b1, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    chk_out("ar.async", 4'd0, 16'h0000, 1'b0, 1'b0);
    chk("ar.sel", 32'(ifc.sel), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    step(16'hFFFF, 16'h0000);
    chk_out("ar.first", 4'd0, 16'h8000, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
